// File: rtl/frame_seq_pkg.sv
// ---------------------------------------------------------------------------
// frame_seq_pkg
//   Shared types and default constants for the frame sequencer.
//   seq_state_t encoding is exported on the status port, so the numeric
//   values are fixed and must not be reordered.
// ---------------------------------------------------------------------------
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        RUN       = 2'd2,
        LATCH     = 2'd3
    } seq_state_t;

    // 23 strings x 236 LEDs x 24 bits, packed into 16-bit FIFO words
    localparam int unsigned DEFAULT_FIFO_ADDR_WIDTH  = 13;
    localparam int unsigned DEFAULT_FRAME_WORDS      = 8142;
    // 300 us of WS281x latch gap at 20 MHz
    localparam int unsigned DEFAULT_LATCH_CYCLES     = 6000;
    // 30 fps ceiling at 20 MHz
    localparam int unsigned DEFAULT_MIN_FRAME_CYCLES = 666667;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that stops at MAX instead of wrapping.
//   Ports:
//     clk      in   1      clock
//     reset_n  in   1      synchronous active-low reset
//     clr      in   1      synchronous clear to 0 (wins over inc)
//     inc      in   1      count enable
//     count    out  WIDTH  current value
//     at_max   out  1      count == MAX
//   RESET_TO_MAX presets the counter to MAX on reset, so a "ready when
//   saturated" user sees ready immediately after reset.
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int          WIDTH        = 8,
    parameter int unsigned MAX          = 255,
    parameter bit          RESET_TO_MAX = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= RESET_TO_MAX ? MAX_V : '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_max = (count == MAX_V);

endmodule

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
//   Schedules colour-string frames in the 20 MHz string clock domain.
//   Keeps the strings blanked until a whole frame sits in the pixel FIFO and
//   the minimum frame period has elapsed, then pulses frame_start. While a
//   frame runs it counts consumed FIFO words; when the string driver stops
//   shifting it checks the word count, forces the WS281x latch gap, and
//   returns to waiting.
//   Ports:
//     clk              in   1     20 MHz string clock
//     reset_n          in   1     synchronous active-low reset
//     enable           in   1     run enable (already synchronised)
//     fifo_full_count  in   FAW+1 words available in the pixel FIFO
//     fifo_read        in   1     FIFO read strobe from the string driver
//     strings_busy     in   1     string driver shifting
//     frame_start      out  1     one-cycle pulse: begin frame
//     h_blank          out  1     1 = strings held blank
//     frame_count      out  16    frames started, wraps
//     frame_err        out  1     one-cycle pulse: bad word count / timeout
//     seq_state        out  2     current state for status readback
// ---------------------------------------------------------------------------
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int          FIFO_ADDR_WIDTH  = DEFAULT_FIFO_ADDR_WIDTH,
    parameter int unsigned FRAME_WORDS      = DEFAULT_FRAME_WORDS,
    parameter int unsigned LATCH_CYCLES     = DEFAULT_LATCH_CYCLES,
    parameter int unsigned MIN_FRAME_CYCLES = DEFAULT_MIN_FRAME_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [FIFO_ADDR_WIDTH:0] fifo_full_count,
    input  logic                     fifo_read,
    input  logic                     strings_busy,
    output logic                     frame_start,
    output logic                     h_blank,
    output logic [15:0]              frame_count,
    output logic                     frame_err,
    output logic [1:0]               seq_state
);

    localparam int          CW        = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned WORD_MAX  = (1 << CW) - 1;
    localparam int          PERIOD_W  = $clog2(MIN_FRAME_CYCLES + 1);
    localparam int          LATCH_W   = $clog2(LATCH_CYCLES + 1);
    localparam logic [CW-1:0] FRAME_WORDS_V = CW'(FRAME_WORDS);

    seq_state_t state;
    seq_state_t next_state;

    logic          busy_q;
    logic          busy_fall;
    logic          start_frame;

    logic [CW-1:0] word_count;
    logic          word_at_max;
    logic [CW-1:0] word_final;

    logic [PERIOD_W-1:0] period_count_unused;
    logic                period_at_max;
    logic [LATCH_W-1:0]  latch_count_unused;
    logic                latch_at_max;

    logic        next_frame_start;
    logic        next_frame_err;
    logic        next_h_blank;
    logic [15:0] next_frame_count;

    // Period counter: free-runs to saturation and is restarted by each
    // frame_start; saturated means the next frame is allowed.
    sat_counter #(
        .WIDTH        (PERIOD_W),
        .MAX          (MIN_FRAME_CYCLES - 1),
        .RESET_TO_MAX (1'b1)
    ) u_period (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_frame),
        .inc     (1'b1),
        .count   (period_count_unused),
        .at_max  (period_at_max)
    );

    // Word counter: only reads during RUN belong to the frame.
    sat_counter #(
        .WIDTH        (CW),
        .MAX          (WORD_MAX),
        .RESET_TO_MAX (1'b0)
    ) u_words (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_frame),
        .inc     (fifo_read && (state == RUN)),
        .count   (word_count),
        .at_max  (word_at_max)
    );

    // Latch counter: held at zero outside LATCH, so the first LATCH cycle
    // always sees 0 and the gap is exactly LATCH_CYCLES long.
    sat_counter #(
        .WIDTH        (LATCH_W),
        .MAX          (LATCH_CYCLES - 1),
        .RESET_TO_MAX (1'b0)
    ) u_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != LATCH),
        .inc     (state == LATCH),
        .count   (latch_count_unused),
        .at_max  (latch_at_max)
    );

    assign busy_fall = busy_q && !strings_busy;

    // Next-state and next-output logic. A read in the cycle the driver goes
    // idle is part of the frame, so the word check uses the count including
    // that read. The period timeout also covers a driver that never goes
    // busy or gets stuck busy; a genuine falling edge takes priority.
    always_comb begin
        next_state       = state;
        start_frame      = 1'b0;
        next_frame_start = 1'b0;
        next_frame_err   = 1'b0;
        next_frame_count = frame_count;

        word_final = word_count;
        if (fifo_read && !word_at_max) begin
            word_final = word_count + CW'(1);
        end

        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if ((fifo_full_count >= FRAME_WORDS_V) && period_at_max) begin
                    next_state       = RUN;
                    start_frame      = 1'b1;
                    next_frame_start = 1'b1;
                    next_frame_count = frame_count + 16'd1;
                end
            end
            RUN: begin
                if (busy_fall) begin
                    next_state     = LATCH;
                    next_frame_err = (word_final != FRAME_WORDS_V);
                end else if (period_at_max) begin
                    next_state     = LATCH;
                    next_frame_err = 1'b1;
                end
            end
            LATCH: begin
                if (latch_at_max) begin
                    next_state = enable ? WAIT_DATA : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        next_h_blank = (next_state != RUN);
    end

    // State and registered outputs; busy_q feeds the falling-edge detect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            h_blank     <= 1'b1;
            frame_count <= 16'd0;
        end else begin
            state       <= next_state;
            busy_q      <= strings_busy;
            frame_start <= next_frame_start;
            frame_err   <= next_frame_err;
            h_blank     <= next_h_blank;
            frame_count <= next_frame_count;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer
//   Directed bench for frame_sequencer with a small frame (36 words),
//   10-cycle latch gap and 100-cycle minimum frame period.
// ---------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int CW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] fifo_full_count;
    logic          fifo_read;
    logic          strings_busy;
    logic          frame_start;
    logic          h_blank;
    logic [15:0]   frame_count;
    logic          frame_err;
    logic [1:0]    seq_state;

    int cyc        = 0;
    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    frame_sequencer #(
        .FIFO_ADDR_WIDTH  (13),
        .FRAME_WORDS      (36),
        .LATCH_CYCLES     (10),
        .MIN_FRAME_CYCLES (100)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .fifo_full_count (fifo_full_count),
        .fifo_read       (fifo_read),
        .strings_busy    (strings_busy),
        .frame_start     (frame_start),
        .h_blank         (h_blank),
        .frame_count     (frame_count),
        .frame_err       (frame_err),
        .seq_state       (seq_state)
    );

    // Advance one clock and settle past the edge before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [CW-1:0] fcc,
                                 input logic rd, input logic busy);
        enable          = en;
        fifo_full_count = fcc;
        fifo_read       = rd;
        strings_busy    = busy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        assert (observed === expected) else begin
            miss_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Bounded wait for the next frame_start pulse.
    task automatic waitStart();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (frame_start === 1'b1) break;
        end
    endtask

    task automatic waitErr();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (frame_err === 1'b1) break;
        end
    endtask

    int first_start;
    int second_start;
    int fifth_start;
    int seen_start;

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 14'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        checkOutput("reset_state", seq_state, 0);
        checkOutput("reset_blank", h_blank, 1);
        checkOutput("reset_count", frame_count, 0);
        checkOutput("reset_start", frame_start, 0);

        // Get into RUN, then reset mid-frame
        applyStimulus(1'b1, 14'd36, 1'b0, 1'b0);
        tick();
        checkOutput("idle_to_wait", seq_state, 1);
        tick();
        checkOutput("pre_reset_start", frame_start, 1);
        checkOutput("pre_reset_state", seq_state, 2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("midrun_reset_state", seq_state, 0);
        checkOutput("midrun_reset_blank", h_blank, 1);
        checkOutput("midrun_reset_count", frame_count, 0);
        checkOutput("midrun_reset_start", frame_start, 0);

        // Threshold: 35 words is not enough, 36 is
        applyStimulus(1'b1, 14'd35, 1'b0, 1'b0);
        tick();
        checkOutput("wait_state", seq_state, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("no_start_at_35", frame_start, 0);
        end
        applyStimulus(1'b1, 14'd36, 1'b0, 1'b0);
        tick();
        checkOutput("start_at_36", frame_start, 1);
        checkOutput("run_unblank", h_blank, 0);
        checkOutput("count_after_first", frame_count, 1);
        first_start = cyc;

        // Full frame: 36 reads, then driver goes idle
        applyStimulus(1'b1, 14'd36, 1'b1, 1'b1);
        for (int i = 0; i < 36; i++) begin
            tick();
            if (i == 0) checkOutput("start_is_pulse", frame_start, 0);
        end
        checkOutput("run_state_full", seq_state, 2);
        applyStimulus(1'b1, 14'd36, 1'b0, 1'b0);
        tick();
        checkOutput("full_latch_state", seq_state, 3);
        checkOutput("full_no_err", frame_err, 0);
        checkOutput("full_latch_blank", h_blank, 1);
        for (int i = 1; i < 10; i++) begin
            tick();
            checkOutput("latch_hold", seq_state, 3);
        end
        tick();
        checkOutput("latch_to_wait", seq_state, 1);

        // Second frame gated by the 100-cycle minimum period
        waitStart();
        checkOutput("second_start", frame_start, 1);
        checkOutput("second_start_spacing", cyc - first_start, 100);
        checkOutput("count_after_second", frame_count, 2);
        second_start = cyc;

        // Short frame: 30 reads
        applyStimulus(1'b1, 14'd36, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) tick();
        applyStimulus(1'b1, 14'd36, 1'b0, 1'b0);
        tick();
        checkOutput("short_err", frame_err, 1);
        checkOutput("short_latch_state", seq_state, 3);
        tick();
        checkOutput("short_err_pulse", frame_err, 0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("short_latch_to_wait", seq_state, 1);

        waitStart();
        checkOutput("third_start", frame_start, 1);
        checkOutput("third_start_spacing", cyc - second_start, 100);
        checkOutput("count_after_third", frame_count, 3);

        // 36th read lands in the same cycle as the busy fall
        applyStimulus(1'b1, 14'd36, 1'b1, 1'b1);
        for (int i = 0; i < 35; i++) tick();
        applyStimulus(1'b1, 14'd36, 1'b1, 1'b0);
        tick();
        checkOutput("sameclk_no_err", frame_err, 0);
        checkOutput("sameclk_latch_state", seq_state, 3);
        applyStimulus(1'b1, 14'd36, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("sameclk_to_wait", seq_state, 1);

        // Disable during RUN: frame and latch finish, then IDLE
        waitStart();
        checkOutput("fourth_start", frame_start, 1);
        checkOutput("count_after_fourth", frame_count, 4);
        applyStimulus(1'b0, 14'd36, 1'b1, 1'b1);
        for (int i = 0; i < 36; i++) tick();
        checkOutput("disabled_run_holds", seq_state, 2);
        applyStimulus(1'b0, 14'd36, 1'b0, 1'b0);
        tick();
        checkOutput("disabled_latch_state", seq_state, 3);
        checkOutput("disabled_no_err", frame_err, 0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("disabled_latch_holds", seq_state, 3);
        tick();
        checkOutput("disabled_to_idle", seq_state, 0);
        checkOutput("idle_blank", h_blank, 1);
        seen_start = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (frame_start === 1'b1) seen_start++;
        end
        checkOutput("idle_no_start", seen_start, 0);
        checkOutput("idle_count_held", frame_count, 4);
        checkOutput("idle_state_held", seq_state, 0);

        // Driver never goes busy: RUN times out after the frame period
        applyStimulus(1'b1, 14'd36, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("fifth_start", frame_start, 1);
        checkOutput("count_after_fifth", frame_count, 5);
        fifth_start = cyc;
        waitErr();
        checkOutput("timeout_err", frame_err, 1);
        checkOutput("timeout_spacing", cyc - fifth_start, 100);
        checkOutput("timeout_latch_state", seq_state, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
